psum_scratchpad: RTL and testbench

//  Partial-sum scratchpad. It is the responder to the design controller's psum_* / accumulate strobes.
//  - FILL mode: the PE datapath accumulates into the current entry and commits it with psum_next.
//  - DRAIN mode (JUST_ADD phase): entries pop in FIFO order, optionally summed with the incoming P_sum buffer word.
//  - Returns psum_empty / psum_full / psum_done status to the controller.

---
 rtl/psum_scratchpad_if.sv | 35 +++
 rtl/psum_scratchpad.sv | 120 ++++++++++++
 tb/tb_psum_scratchpad.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/psum_scratchpad_if.sv
// Controller <-> partial-sum scratchpad strobe/status bundle.
// Latency: none (wires only).
// Backpressure: none; the controller reads empty/full and must respect them.
interface psum_scratchpad_if #(
    parameter int WIDTH = 16
);
    logic             psum_clear;
    logic             psum_same_addr;
    logic             psum_wen;
    logic [WIDTH-1:0] psum_in;
    logic             psum_next;
    logic             psum_ren;
    logic             accumulate;
    logic [WIDTH-1:0] add_in;
    logic [WIDTH-1:0] psum_out;
    logic             psum_out_valid;
    logic             psum_empty;
    logic             psum_full;
    logic             psum_done;
    logic             psum_ovf;

    // Controller side drives strobes and watches status
    modport master (
        output psum_clear, psum_same_addr, psum_wen, psum_in, psum_next,
               psum_ren, accumulate, add_in,
        input  psum_out, psum_out_valid, psum_empty, psum_full, psum_done, psum_ovf
    );

    // Scratchpad side responds to strobes
    modport slave (
        input  psum_clear, psum_same_addr, psum_wen, psum_in, psum_next,
               psum_ren, accumulate, add_in,
        output psum_out, psum_out_valid, psum_empty, psum_full, psum_done, psum_ovf
    );
endinterface

// File: rtl/psum_scratchpad.sv
// Partial-sum scratchpad: FILL accumulates/commits entries, DRAIN pops them in FIFO order.
// Latency: pop -> psum_out/psum_out_valid 1 clock; empty/full combinational from count.
// Backpressure: none; writes/commits while full are dropped (sticky ovf), pops while empty ignored.
module psum_scratchpad #(
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    psum_scratchpad_if.slave  bus
);
    localparam int ADDR_W = $clog2(SCRATCH_DEPTH);
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [SCRATCH_WIDTH-1:0] r_mem [SCRATCH_DEPTH];
    logic [SCRATCH_DEPTH-1:0] r_open;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [ADDR_W-1:0]        r_rd_ptr;
    logic [ADDR_W:0]          r_count;
    logic [0:0]               r_state;
    logic [SCRATCH_WIDTH-1:0] r_out;
    logic                     r_out_vld;
    logic                     r_done;
    logic                     r_ovf;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_fill;
    logic                     w_write;
    logic                     w_commit;
    logic                     w_drop;
    logic                     w_pop;
    logic [SCRATCH_WIDTH-1:0] w_base;
    logic [SCRATCH_WIDTH-1:0] w_wdat;
    logic [SCRATCH_WIDTH-1:0] w_rdat;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (ADDR_W+1)'(SCRATCH_DEPTH));
    // Write side only acts in settled FILL; the DRAIN->FILL turnaround cycle is a bubble.
    assign w_fill   = (r_state == ST_FILL) && bus.psum_same_addr;
    assign w_write  = w_fill && bus.psum_wen  && !w_full;
    assign w_commit = w_fill && bus.psum_next && !w_full;
    assign w_drop   = w_fill && (bus.psum_wen || bus.psum_next) && w_full;
    // Pop is legal in DRAIN and in the FILL->DRAIN transition cycle alike.
    assign w_pop    = !bus.psum_same_addr && bus.psum_ren && !w_empty;

    // A closed entry starts from zero, so an unwritten commit stores 0.
    assign w_base = r_open[r_wr_ptr] ? r_mem[r_wr_ptr] : '0;
    assign w_wdat = w_base + (bus.psum_wen ? bus.psum_in : '0);
    assign w_rdat = r_mem[r_rd_ptr] + (bus.accumulate ? bus.add_in : '0);

    // Entry storage: accumulate on write, and settle the committed value on commit
    always_ff @(posedge i_clk) begin
        if (w_write || w_commit) begin
            r_mem[r_wr_ptr] <= w_wdat;
        end
    end

    // Mode FSM: FILL -> DRAIN on first pop request, back on same_addr
    always_ff @(posedge i_clk) begin
        if (!i_rst || bus.psum_clear) begin
            r_state <= ST_FILL;
        end else begin
            case (r_state)
                ST_FILL:  if (!bus.psum_same_addr && bus.psum_ren) r_state <= ST_DRAIN;
                ST_DRAIN: if (bus.psum_same_addr)                  r_state <= ST_FILL;
                default:  r_state <= ST_FILL;
            endcase
        end
    end

    // Pointers, count, open flags and sticky overflow
    always_ff @(posedge i_clk) begin
        if (!i_rst || bus.psum_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_open   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_commit) begin
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                r_count          <= r_count + 1'b1;
                r_open[r_wr_ptr] <= 1'b0;
            end else if (w_write) begin
                r_open[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Registered drain output; done marks the word that empties the pad
    always_ff @(posedge i_clk) begin
        if (!i_rst || bus.psum_clear) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_out_vld <= w_pop;
            r_done    <= w_pop && (r_count == (ADDR_W+1)'(1));
            if (w_pop) begin
                r_out <= w_rdat;
            end
        end
    end

    assign bus.psum_out       = r_out;
    assign bus.psum_out_valid = r_out_vld;
    assign bus.psum_empty     = w_empty;
    assign bus.psum_full      = w_full;
    assign bus.psum_done      = r_done;
    assign bus.psum_ovf       = r_ovf;
endmodule

// File: tb/tb_psum_scratchpad.sv
// Directed bench for psum_scratchpad at DEPTH=4, WIDTH=16.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a; stimulus is a fixed linear sequence.
module tb_psum_scratchpad;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    psum_scratchpad_if #(.WIDTH(16)) bus ();

    psum_scratchpad #(
        .SCRATCH_DEPTH(4),
        .SCRATCH_WIDTH(16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.psum_clear = 1'b0; bus.psum_wen = 1'b0; bus.psum_next = 1'b0;
        bus.psum_ren = 1'b0; bus.accumulate = 1'b0;
        bus.psum_in = '0; bus.add_in = '0;
    endtask

    // FILL-mode write with optional commit
    task automatic wr(input logic [15:0] val, input logic nxt);
        idle();
        bus.psum_same_addr = 1'b1; bus.psum_wen = 1'b1; bus.psum_in = val; bus.psum_next = nxt;
        step();
    endtask

    // DRAIN-mode pop
    task automatic pop(input logic acc, input logic [15:0] addv);
        idle();
        bus.psum_same_addr = 1'b0; bus.psum_ren = 1'b1; bus.accumulate = acc; bus.add_in = addv;
        step();
    endtask

    // Return to FILL with a bubble cycle
    task automatic to_fill();
        idle();
        bus.psum_same_addr = 1'b1;
        step();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle();
        bus.psum_same_addr = 1'b1;

        // 1. reset
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk1("rst_empty", bus.psum_empty, 1'b1);
        chk1("rst_full",  bus.psum_full, 1'b0);
        chk1("rst_vld",   bus.psum_out_valid, 1'b0);
        chk1("rst_ovf",   bus.psum_ovf, 1'b0);
        chk1("rst_done",  bus.psum_done, 1'b0);
        chk16("rst_out",  bus.psum_out, 16'h0000);

        // 2. fill 3+5 -> 8, 7 -> 7; drain without accumulate
        wr(16'd3, 1'b0);
        wr(16'd5, 1'b1);
        wr(16'd7, 1'b1);
        chk1("fill_empty", bus.psum_empty, 1'b0);
        pop(1'b0, 16'd0);
        chk16("d0_out",  bus.psum_out, 16'd8);
        chk1("d0_vld",   bus.psum_out_valid, 1'b1);
        chk1("d0_done",  bus.psum_done, 1'b0);
        pop(1'b0, 16'd0);
        chk16("d1_out",  bus.psum_out, 16'd7);
        chk1("d1_done",  bus.psum_done, 1'b1);
        chk1("d1_empty", bus.psum_empty, 1'b1);
        idle(); bus.psum_same_addr = 1'b0; step();
        chk1("d2_vld",   bus.psum_out_valid, 1'b0);
        chk1("d2_done",  bus.psum_done, 1'b0);
        chk16("d2_hold", bus.psum_out, 16'd7);

        // 3. accumulate wrap 0x7FFF + 1
        to_fill();
        wr(16'h7FFF, 1'b1);
        pop(1'b1, 16'h0001);
        chk16("acc_out", bus.psum_out, 16'h8000);
        chk1("acc_done", bus.psum_done, 1'b1);

        // 4. full and overflow
        to_fill();
        wr(16'd10, 1'b1);
        wr(16'd20, 1'b1);
        wr(16'd30, 1'b1);
        chk1("f3_full", bus.psum_full, 1'b0);
        wr(16'd40, 1'b1);
        chk1("f4_full", bus.psum_full, 1'b1);
        chk1("f4_ovf",  bus.psum_ovf, 1'b0);
        wr(16'd99, 1'b1);
        chk1("ovf_set",  bus.psum_ovf, 1'b1);
        chk1("ovf_full", bus.psum_full, 1'b1);
        idle(); step();
        chk1("ovf_sticky", bus.psum_ovf, 1'b1);
        bus.psum_clear = 1'b1; step();
        chk1("clr_empty", bus.psum_empty, 1'b1);
        chk1("clr_full",  bus.psum_full, 1'b0);
        chk1("clr_ovf",   bus.psum_ovf, 1'b0);

        // 5. pointer wrap: 3 in/out, then 3 more across the wrap
        wr(16'd1, 1'b1);
        wr(16'd2, 1'b1);
        wr(16'd3, 1'b1);
        pop(1'b0, 16'd0);
        chk16("w0_out", bus.psum_out, 16'd1);
        chk1("w0_done", bus.psum_done, 1'b0);
        pop(1'b0, 16'd0);
        chk16("w1_out", bus.psum_out, 16'd2);
        pop(1'b0, 16'd0);
        chk16("w2_out", bus.psum_out, 16'd3);
        chk1("w2_done", bus.psum_done, 1'b1);
        to_fill();
        wr(16'd4, 1'b1);
        wr(16'd5, 1'b1);
        wr(16'd6, 1'b1);
        pop(1'b0, 16'd0);
        chk16("w3_out", bus.psum_out, 16'd4);
        chk1("w3_done", bus.psum_done, 1'b0);
        pop(1'b0, 16'd0);
        chk16("w4_out", bus.psum_out, 16'd5);
        chk1("w4_done", bus.psum_done, 1'b0);
        pop(1'b0, 16'd0);
        chk16("w5_out", bus.psum_out, 16'd6);
        chk1("w5_done", bus.psum_done, 1'b1);
        chk1("w5_empty", bus.psum_empty, 1'b1);

        // 6. pop while empty, then clear together with a pop mid-drain
        pop(1'b0, 16'd0);
        chk1("pe_vld",   bus.psum_out_valid, 1'b0);
        chk1("pe_done",  bus.psum_done, 1'b0);
        chk16("pe_hold", bus.psum_out, 16'd6);
        to_fill();
        wr(16'd11, 1'b1);
        wr(16'd12, 1'b1);
        pop(1'b0, 16'd0);
        chk16("mc_out", bus.psum_out, 16'd11);
        idle(); bus.psum_same_addr = 1'b0; bus.psum_ren = 1'b1; bus.psum_clear = 1'b1;
        step();
        chk1("mc_vld",   bus.psum_out_valid, 1'b0);
        chk1("mc_empty", bus.psum_empty, 1'b1);
        chk1("mc_done",  bus.psum_done, 1'b0);
        idle(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
